// File: rtl/fcpu_pkg.sv
// Shared processor-wide widths and the common data bus entry layout.
package fcpu_pkg;

    localparam int RSV_ID_W = 4;
    localparam int DATA_W   = 16;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    typedef struct packed {
        logic [RSV_ID_W-1:0] rsv_id;
        logic [DATA_W-1:0]   data;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arb_slot.sv
// Two-entry FIFO buffering one functional unit's results ahead of CDB arbitration.
module cdb_arb_slot
    import fcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  cdb_entry_t push_data,
    input  logic       pop,
    output cdb_entry_t head_data,
    output logic       not_empty,
    output logic       ready
);

    cdb_entry_t mem [2];
    logic [1:0] count;
    logic [1:0] count_next;
    logic       rd_ptr;
    logic       wr_ptr;

    assign count_next = count + {1'b0, push} - {1'b0, pop};
    assign head_data  = mem[rd_ptr];
    assign not_empty  = (count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            ready  <= 1'b0;
        end else begin
            count  <= count_next;
            // ready reflects occupancy after this edge, so a full slot is never pushed
            ready  <= (count_next != 2'd2);
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // NOTE: storage has no reset; count alone decides validity, so stale entries are never read out.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one common data bus among N_SOURCES functional units,
// each buffered by a two-entry slot; winner is registered onto the bus next cycle.
module cdb_arbiter
    import fcpu_pkg::*;
#(
    parameter int N_SOURCES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SOURCES*CDB_W-1:0] i_cdb,
    input  logic [N_SOURCES-1:0]       i_valid,
    output logic [N_SOURCES-1:0]       i_ready,
    output logic [CDB_W-1:0]           cdb,
    output logic                       cdb_valid,
    output logic [N_SOURCES-1:0]       o_grant
);

    localparam int PTR_W = $clog2(N_SOURCES);

    cdb_entry_t           head_data [N_SOURCES];
    logic [N_SOURCES-1:0] not_empty;
    logic [N_SOURCES-1:0] push;
    logic [N_SOURCES-1:0] pop;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W:0]       idx;
    logic                 found;

    assign push = i_valid & i_ready;

    for (genvar k = 0; k < N_SOURCES; k++) begin : g_slot
        cdb_arb_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .push      (push[k]),
            .push_data (i_cdb[k*CDB_W +: CDB_W]),
            .pop       (pop[k]),
            .head_data (head_data[k]),
            .not_empty (not_empty[k]),
            .ready     (i_ready[k])
        );
    end

    // NOTE: every variable gets a default first so this block cannot infer a latch.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = 0; i < N_SOURCES; i++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(N_SOURCES)) idx = idx - (PTR_W+1)'(N_SOURCES);
            if (!found && not_empty[idx[PTR_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        if (found) pop[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            cdb       <= '0;
            cdb_valid <= 1'b0;
            o_grant   <= '0;
        end else begin
            cdb_valid <= found;
            o_grant   <= pop;
            if (found) begin
                cdb <= head_data[gnt_idx];
                ptr <= (gnt_idx == PTR_W'(N_SOURCES-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with four sources.
module tb_cdb_arbiter;
    import fcpu_pkg::*;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N*CDB_W-1:0]   i_cdb;
    logic [N-1:0]         i_valid;
    logic [N-1:0]         i_ready;
    logic [CDB_W-1:0]     cdb;
    logic                 cdb_valid;
    logic [N-1:0]         o_grant;

    int checks = 0;
    int errors = 0;
    int sent  [N];
    int rcvd  [N];
    int limit [N];

    cdb_arbiter #(.N_SOURCES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_cdb     (i_cdb),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .cdb       (cdb),
        .cdb_valid (cdb_valid),
        .o_grant   (o_grant)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CDB_W-1:0] ent(input int tag, input int data);
        return {RSV_ID_W'(tag), DATA_W'(data)};
    endfunction

    function automatic int seq_data(input int k, input int seq);
        return 'hA000 + k * 256 + seq;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_inputs();
        for (int k = 0; k < N; k++) begin
            i_valid[k] = (sent[k] < limit[k]);
            i_cdb[k*CDB_W +: CDB_W] = ent(k, seq_data(k, sent[k]));
        end
    endtask

    // One clock of streaming traffic: count handshakes, check broadcasts in per-source order.
    task automatic drive_cycle();
        logic [N-1:0] hs;
        hs = i_valid & i_ready;
        step();
        for (int k = 0; k < N; k++)
            if (hs[k]) sent[k]++;
        if (cdb_valid) begin
            check("grant_onehot", 32'($onehot(o_grant)), 32'd1);
            for (int k = 0; k < N; k++) begin
                if (o_grant[k]) begin
                    check($sformatf("stream_src%0d_seq%0d", k, rcvd[k]), 32'(cdb),
                          32'(ent(k, seq_data(k, rcvd[k]))));
                    rcvd[k]++;
                end
            end
        end
        load_inputs();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = '0;
        i_cdb   = '0;
        step();
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k < N; k++) begin
            sent[k]  = 0;
            rcvd[k]  = 0;
            limit[k] = 0;
        end
    endtask

    initial begin
        // Reset held three cycles with every source requesting
        rst     = 1'b1;
        i_valid = 4'b1111;
        i_cdb   = {N{ent(9, 'h1234)}};
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("rst_valid_c%0d", c), 32'(cdb_valid), 32'd0);
            check($sformatf("rst_ready_c%0d", c), 32'(i_ready), 32'd0);
            check($sformatf("rst_grant_c%0d", c), 32'(o_grant), 32'd0);
            check($sformatf("rst_cdb_c%0d", c), 32'(cdb), 32'd0);
        end
        rst     = 1'b0;
        i_valid = '0;
        step();
        check("post_rst_ready", 32'(i_ready), 32'hF);
        check("post_rst_valid", 32'(cdb_valid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("post_rst_idle_c%0d", c), 32'(cdb_valid), 32'd0);
        end

        // Single source 2 sends tags 5,6,7 back to back
        i_valid = 4'b0100;
        i_cdb[2*CDB_W +: CDB_W] = ent(5, 'h0555);
        step();
        check("single_lat_c1", 32'(cdb_valid), 32'd0);
        check("single_ready2", 32'(i_ready[2]), 32'd1);
        i_cdb[2*CDB_W +: CDB_W] = ent(6, 'h0666);
        step();
        check("single_valid5", 32'(cdb_valid), 32'd1);
        check("single_cdb5", 32'(cdb), 32'(ent(5, 'h0555)));
        check("single_grant5", 32'(o_grant), 32'h4);
        i_cdb[2*CDB_W +: CDB_W] = ent(7, 'h0777);
        step();
        check("single_cdb6", 32'(cdb), 32'(ent(6, 'h0666)));
        check("single_ready2_b", 32'(i_ready[2]), 32'd1);
        i_valid = '0;
        step();
        check("single_cdb7", 32'(cdb), 32'(ent(7, 'h0777)));
        check("single_grant7", 32'(o_grant), 32'h4);
        step();
        check("single_idle_valid", 32'(cdb_valid), 32'd0);
        check("single_idle_grant", 32'(o_grant), 32'd0);
        check("single_idle_hold", 32'(cdb), 32'(ent(7, 'h0777)));

        // Full contention from ptr=0: strict 0,1,2,3 rotation with no gaps
        do_reset();
        for (int k = 0; k < N; k++) limit[k] = 100;
        load_inputs();
        for (int n = 0; n < 14; n++) begin
            drive_cycle();
            if (n == 0) begin
                check("rr_first_idle", 32'(cdb_valid), 32'd0);
            end else begin
                check($sformatf("rr_valid_n%0d", n), 32'(cdb_valid), 32'd1);
                check($sformatf("rr_grant_n%0d", n), 32'(o_grant), 32'(1 << ((n - 1) % N)));
            end
        end
        for (int k = 0; k < N; k++) limit[k] = sent[k];
        load_inputs();
        for (int n = 0; n < 12; n++) drive_cycle();
        for (int k = 0; k < N; k++)
            check($sformatf("rr_drain_src%0d", k), 32'(rcvd[k]), 32'(sent[k]));

        // Back-pressure: source 1 pushes 3 while the others stay valid
        do_reset();
        limit[0] = 6;
        limit[1] = 3;
        limit[2] = 6;
        limit[3] = 6;
        load_inputs();
        drive_cycle();
        check("bp_ready_e1", 32'(i_ready), 32'hF);
        drive_cycle();
        check("bp_ready_e2", 32'(i_ready), 32'h1);
        for (int n = 0; n < 30; n++) drive_cycle();
        for (int k = 0; k < N; k++) begin
            check($sformatf("bp_sent_src%0d", k), 32'(sent[k]), 32'(limit[k]));
            check($sformatf("bp_rcvd_src%0d", k), 32'(rcvd[k]), 32'(limit[k]));
        end

        // Wrap/skip: park ptr at 3, then only sources 0 and 2 hold entries
        do_reset();
        i_valid = 4'b0100;
        i_cdb[2*CDB_W +: CDB_W] = ent(2, 'h00A0);
        step();
        i_valid = 4'b0101;
        i_cdb[0*CDB_W +: CDB_W] = ent(0, 'h00B0);
        i_cdb[2*CDB_W +: CDB_W] = ent(2, 'h00C0);
        step();
        check("wrap_first_grant", 32'(o_grant), 32'h4);
        check("wrap_first_cdb", 32'(cdb), 32'(ent(2, 'h00A0)));
        i_valid = '0;
        step();
        check("wrap_grant0", 32'(o_grant), 32'h1);
        check("wrap_cdb0", 32'(cdb), 32'(ent(0, 'h00B0)));
        step();
        check("wrap_grant2", 32'(o_grant), 32'h4);
        check("wrap_cdb2", 32'(cdb), 32'(ent(2, 'h00C0)));
        i_valid = 4'b1001;
        i_cdb[0*CDB_W +: CDB_W] = ent(0, 'h00D0);
        i_cdb[3*CDB_W +: CDB_W] = ent(3, 'h00E0);
        step();
        check("wrap_gap_valid", 32'(cdb_valid), 32'd0);
        check("wrap_gap_hold", 32'(cdb), 32'(ent(2, 'h00C0)));
        i_valid = '0;
        step();
        check("wrap_ptr3_grant", 32'(o_grant), 32'h8);
        check("wrap_ptr3_cdb", 32'(cdb), 32'(ent(3, 'h00E0)));
        step();
        check("wrap_then0_grant", 32'(o_grant), 32'h1);
        check("wrap_then0_cdb", 32'(cdb), 32'(ent(0, 'h00D0)));
        step();
        check("wrap_end_valid", 32'(cdb_valid), 32'd0);

        // Mid-stream reset with six entries buffered
        do_reset();
        i_valid = 4'b1111;
        for (int k = 0; k < N; k++) i_cdb[k*CDB_W +: CDB_W] = ent(8 + k, 'hBEE0 + k);
        step();
        i_valid = 4'b1110;
        for (int k = 0; k < N; k++) i_cdb[k*CDB_W +: CDB_W] = ent(8 + k, 'hBEF0 + k);
        step();
        check("mid_pre_grant", 32'(o_grant), 32'h1);
        check("mid_pre_cdb", 32'(cdb), 32'(ent(8, 'hBEE0)));
        rst     = 1'b1;
        i_valid = '0;
        step();
        check("mid_rst_valid", 32'(cdb_valid), 32'd0);
        check("mid_rst_grant", 32'(o_grant), 32'd0);
        check("mid_rst_cdb", 32'(cdb), 32'd0);
        check("mid_rst_ready", 32'(i_ready), 32'd0);
        rst = 1'b0;
        step();
        check("mid_post_ready", 32'(i_ready), 32'hF);
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("mid_flush_valid_c%0d", c), 32'(cdb_valid), 32'd0);
            check($sformatf("mid_flush_cdb_c%0d", c), 32'(cdb), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL take parameter N_SOURCES, default 4, range 2..8: number of functional units sharing the CDB.
REQ-002 SHALL take clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL take rst, input, 1: reset; one clock, synchronous, active-high.
REQ-004 SHALL take i_cdb, input, N_SOURCES*CDB_W: per-source result {RSV_ID, DATA}; source k occupies bits [k*CDB_W +: CDB_W].
REQ-005 SHALL take i_valid, input, N_SOURCES: per-source result valid.
REQ-006 SHALL drive i_ready, output, N_SOURCES: per-source accept; registered, no combinational path from any input.
REQ-007 SHALL drive cdb, output, CDB_W: broadcast tag+data.
REQ-008 SHALL drive cdb_valid, output, 1: broadcast valid; no back-pressure, all listeners sample it every cycle.
REQ-009 SHALL drive o_grant, output, N_SOURCES: one-hot source of the current broadcast; zero when cdb_valid=0.

Function
REQ-010 Source k transfer SHALL occur on a cycle with i_valid[k]=1 and i_ready[k]=1; i_cdb[k] captured into slot k.
REQ-011 Each source SHALL own a 2-entry FIFO slot; i_ready[k]=1 iff slot occupancy after the current edge is <2.
REQ-012 A slot at occupancy 2 that is granted and written in the same cycle SHALL NOT occur, because i_ready=0; at occupancy 1, a simultaneous push and grant SHALL keep occupancy 1 with order preserved.
REQ-013 Each cycle the arbiter SHALL grant exactly one non-empty slot, or none if all are empty.
REQ-014 Arbitration SHALL be round-robin: search starts at index ptr, increasing with wrap from N_SOURCES-1 to 0; the first non-empty slot wins.
REQ-015 After a grant to slot g, ptr SHALL become (g+1) mod N_SOURCES; with no grant, ptr SHALL hold.
REQ-016 The granted head entry SHALL be popped and registered into cdb/o_grant, with cdb_valid=1 on the next cycle; latency from transfer into an empty, uncontended slot to cdb_valid is 2 cycles.
REQ-017 cdb_valid SHALL be 0 on every cycle after one in which no slot was granted; cdb SHALL then hold its last value.
REQ-018 Throughput SHALL be one broadcast per cycle when any slot is non-empty; a single continuously valid source SHALL sustain 1 result per cycle.
REQ-019 With all N_SOURCES slots continuously non-empty, each source SHALL be granted exactly once in any N_SOURCES consecutive cycles; worst-case wait N_SOURCES-1 cycles.
REQ-020 Entries SHALL be broadcast unmodified; no tag or data bits are altered.
REQ-021 A source with i_valid=0 SHALL never enter arbitration.

Reset
REQ-022 While rst=1 on a clock edge: all slots empty, ptr=0, cdb_valid=0, o_grant=0, cdb=0, i_ready=0.
REQ-023 The cycle after rst deasserts, i_ready SHALL be all-ones; inputs presented during reset SHALL be dropped.
REQ-024 Reset asserted mid-stream SHALL discard all buffered and in-flight results with no partial broadcast.

Structure
REQ-025 CDB_W, RSV_ID_W and DATA_W SHALL come from fcpu_pkg; N_SOURCES SHALL be a module parameter, not a package constant.
REQ-026 The 2-entry per-source buffer SHALL be sub-module cdb_arb_slot, instantiated N_SOURCES times, with ports clk, rst, push, push_data, pop, head_data, not_empty, ready.
REQ-027 The round-robin pointer and output register SHALL reside in cdb_arbiter.

Verification
REQ-028 Reset: hold rst for 3 cycles with i_valid=4'b1111 -> cdb_valid=0 and i_ready=0 throughout; next cycle i_ready=4'b1111; no broadcast follows.
REQ-029 Single source: source 2 sends tags 5,6,7 on consecutive cycles -> cdb_valid on cycles +2,+3,+4 with tags 5,6,7, o_grant=4'b0100.
REQ-030 Full contention: all 4 sources valid continuously from ptr=0 -> grant sequence 0,1,2,3,0,1,... with one broadcast per cycle and no gaps.
REQ-031 Back-pressure: source 1 pushes 3 entries in a row while sources 0,2,3 stay continuously valid -> i_ready[1]=0 after its slot fills; no entry is lost or reordered.
REQ-032 Wrap/skip: ptr=3, only sources 0 and 2 non-empty -> source 0 granted, then source 2; ptr ends at 3.
REQ-033 Mid-stream reset: 6 entries buffered across slots, rst pulsed 1 cycle -> cdb_valid=0 the next cycle and no buffered tag ever appears on cdb.
